// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared op, state and HI/LO select encodings for the multiply/divide path
package muldiv_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_MULT = 3'd1,
      OP_DIV  = 3'd2,
      OP_MFHI = 3'd3,
      OP_MFLO = 3'd4,
      OP_MTHI = 3'd5,
      OP_MTLO = 3'd6,
      OP_NOP7 = 3'd7
   } mdc_op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_SETTLE = 3'd3,
      ST_READ   = 3'd4
   } mdc_state_e;

   localparam logic SEL_HIGH = 1'b1;
   localparam logic SEL_LOW  = 1'b0;
   localparam logic SEL_MUL  = 1'b0;
   localparam logic SEL_DIV  = 1'b1;

   function automatic logic op_sel_hl(input mdc_op_e code);
      return (code == OP_MFHI || code == OP_MTHI) ? SEL_HIGH : SEL_LOW;
   endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - EX-stage initiator for the HI/LO multiply/divide unit
// MDC_TIMEOUT_EN adds a bounded WAIT state with a sticky MDC_Error flag.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        MDC_Valid,
   input  logic [2:0]  MDC_Op,
   input  logic [31:0] MDC_RsData,
   input  logic [31:0] MDC_RtData,
   output logic        MDC_Stall,
   output logic [31:0] MDC_RdData,
   output logic        MDC_RdValid,
   output logic        MDC_DivZero,
   output logic        MDC_Error,
   output logic        MUL_Start,
   output logic        MUL_SelMD,
   output logic        MUL_SelHL,
   output logic        MUL_Write,
   output logic [31:0] MUL_DA,
   output logic [31:0] MUL_DB,
   input  logic        MUL_Flag,
   input  logic [31:0] MUL_DC
);

   mdc_state_e  state, state_next;
   mdc_op_e     op;
   logic        accept;
   logic        capture;
   logic        set_divzero;
   logic        take_read;
   logic        timeout_hit;
   logic        sel_md_q;
   logic        sel_hl_q;
   logic [31:0] da_q;
   logic [31:0] db_q;

   assign op = mdc_op_e'(MDC_Op);

   // Gated by reset so that the combinational strobes also drop while reset is held.
   assign accept = Reset_n & MDC_Valid & (state == ST_IDLE);

   assign MUL_SelMD = sel_md_q;
   assign MUL_DB    = db_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      MDC_Stall   = 1'b0;
      MUL_Start   = 1'b0;
      MUL_Write   = 1'b0;
      MUL_SelHL   = 1'b0;
      MUL_DA      = da_q;
      capture     = 1'b0;
      set_divzero = 1'b0;
      take_read   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               case (op)
                  OP_MULT, OP_DIV: begin
                     if (op == OP_DIV && MDC_RtData == 32'd0) begin
                        set_divzero = 1'b1;
                     end else begin
                        capture    = 1'b1;
                        MDC_Stall  = 1'b1;
                        state_next = ST_START;
                     end
                  end
                  OP_MFHI, OP_MFLO: begin
                     MDC_Stall  = 1'b1;
                     MUL_SelHL  = op_sel_hl(op);
                     take_read  = 1'b1;
                     state_next = ST_READ;
                  end
                  OP_MTHI, OP_MTLO: begin
                     MUL_Write = 1'b1;
                     MUL_SelHL = op_sel_hl(op);
                     MUL_DA    = MDC_RsData;
                  end
                  default: ;
               endcase
            end
         end
         ST_START: begin
            MUL_Start  = 1'b1;
            MDC_Stall  = 1'b1;
            state_next = ST_WAIT;
         end
         // Only this state looks at the flag; a level left over from the previous op is ignored elsewhere.
         ST_WAIT: begin
            MDC_Stall = 1'b1;
            if (MUL_Flag || timeout_hit) begin
               state_next = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            state_next = ST_IDLE;
         end
         ST_READ: begin
            MUL_SelHL  = sel_hl_q;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         da_q        <= 32'd0;
         db_q        <= 32'd0;
         sel_md_q    <= SEL_MUL;
         sel_hl_q    <= SEL_LOW;
         MDC_RdData  <= 32'd0;
         MDC_RdValid <= 1'b0;
         MDC_DivZero <= 1'b0;
      end else begin
         if (capture) begin
            da_q     <= MDC_RsData;
            db_q     <= MDC_RtData;
            sel_md_q <= (op == OP_DIV) ? SEL_DIV : SEL_MUL;
         end
         if (take_read) begin
            sel_hl_q <= op_sel_hl(op);
         end
         if (state == ST_READ) begin
            MDC_RdData <= MUL_DC;
         end
         MDC_RdValid <= (state == ST_READ);
         MDC_DivZero <= set_divzero;
      end
   end

`ifdef MDC_TIMEOUT_EN
   logic [7:0] wait_cnt;

   assign timeout_hit = (state == ST_WAIT) && !MUL_Flag &&
                        (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         wait_cnt  <= 8'd0;
         MDC_Error <= 1'b0;
      end else begin
         if (state == ST_START) begin
            wait_cnt <= 8'd0;
         end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
         if (timeout_hit) begin
            MDC_Error <= 1'b1;
         end
      end
   end
`else
   logic unused_timeout;

   assign timeout_hit    = 1'b0;
   assign MDC_Error      = 1'b0;
   assign unused_timeout = ^8'(TIMEOUT_CYCLES);
`endif

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Pipeline-side initiator for the HI/LO multiply/divide unit. Accepts decoded MULT/DIV/MFHI/MFLO/MTHI/MTLO operations from the execute stage, sequences the unit's start/flag handshake and HI/LO access strobes, and stalls the pipeline until each operation can retire. It sits between the EX-stage decoder and the multiply/divide unit; the unit's operand, strobe and select inputs are driven only by this block.

## Interface
- TIMEOUT_CYCLES, 64: WAIT-state cycles before abort (timeout build only).
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- MDC_Valid  in  1  operation present on MDC_Op; held stable while MDC_Stall=1.
- MDC_Op  in  3  0 NOP, 1 MULT, 2 DIV, 3 MFHI, 4 MFLO, 5 MTHI, 6 MTLO, 7 NOP.
- MDC_RsData  in  32  operand A, or the MT* write data.
- MDC_RtData  in  32  operand B.
- MDC_Stall  out  1  combinational; hold the pipeline this cycle.
- MDC_RdData  out  32  registered MF* result.
- MDC_RdValid  out  1  one-cycle pulse; MDC_RdData valid.
- MDC_DivZero  out  1  one-cycle pulse; DIV with RtData=0 skipped.
- MDC_Error  out  1  sticky timeout flag, cleared only by reset (timeout build only).
- MUL_Start, MUL_SelMD, MUL_SelHL, MUL_Write  out  1  unit controls (SelMD 0=mul, 1=div; SelHL 1=HI, 0=LO).
- MUL_DA, MUL_DB  out  32  unit operands / write data.
- MUL_Flag  in  1  unit result ready (level).
- MUL_DC  in  32  unit HI/LO read data.

## Operation
- States: IDLE, START, WAIT, SETTLE, READ.
- IDLE, MDC_Valid=0 or NOP: all strobes 0, Stall=0.
- IDLE, MULT, or DIV with RtData≠0: capture Rs/Rt into operand registers, latch SelMD; Stall=1; go START.
- IDLE, DIV with RtData=0: no start issued, HI/LO untouched; Stall=0 (retires); DivZero pulses next cycle.
- START: MUL_Start=1 for exactly this cycle; Stall=1; go WAIT.
- WAIT: Stall=1; on MUL_Flag=1 go SETTLE.
- SETTLE: Stall=0 (the operation retires); go IDLE. HI/LO are readable from the next cycle.
- IDLE, MFHI/MFLO: drive SelHL (HI=1); Stall=1; go READ. READ: keep SelHL; MUL_DC registered into MDC_RdData at the end of READ; RdValid=1 the following cycle; Stall=0 in READ; go IDLE.
- IDLE, MTHI/MTLO: MUL_Write=1 and SelHL set combinationally, MUL_DA=RsData; Stall=0; single cycle.
- In any state other than IDLE, a new operation on MDC_Valid is not accepted. In START/WAIT the pending operation holds Stall=1 until it is accepted.
- MUL_DA/MUL_DB hold the captured operands from START until the next capture. MT* drives MUL_DA from RsData combinationally.
- MDC_Valid is ignored in START/WAIT; no flush. An accepted MULT/DIV always runs to completion.

## Timing
- Reset: state IDLE. Every output is 0, including RdData, the operand registers and Error. Reset mid-operation aborts immediately; no Start is emitted after reset is released.
- MULT/DIV: accept cycle N; Start in N+1; WAIT from N+2; Flag first sampled in N+2. With the flag seen in cycle K, the operation retires in K+1. Minimum 4 cycles, Stall high for 3.
- MF*: accept N (Stall=1); READ N+1; RdValid and RdData in N+2.
- MT*: 0 stall cycles.
- Back-to-back: a new operation is accepted in the first IDLE cycle after SETTLE or READ.
- A stale MUL_Flag=1 in IDLE or START is ignored. Only WAIT samples the flag.

## Configuration
- MDC_TIMEOUT_EN defined: 8-bit WAIT counter, cleared on entry to WAIT. If the counter reaches TIMEOUT_CYCLES with no flag:
  - set MDC_Error;
  - go SETTLE (Stall released, the operation retires) and then IDLE.
- MDC_TIMEOUT_EN undefined: no counter, WAIT is unbounded, MDC_Error tied to 0, TIMEOUT_CYCLES unused.

## Structure
- Shared package: the MDC_Op encodings, the state encodings, and the SelHL/SelMD constants (HIGH=1, LOW=0, MUL=0, DIV=1). The multiply/divide unit uses the same constants.
- Single module. The optional timeout counter is inline and needs no sub-module.

## Test plan
- MULT Rs=0x0000_0003, Rt=0x0000_0005 against a unit model with 2-cycle flag latency:
  - exactly one Start pulse, Stall high for 4 cycles;
  - a following MFLO returns 0x0000_000F with RdValid 2 cycles after acceptance, and MFHI returns 0.
- DIV 17/5: MFHI returns 2 and MFLO returns 3. DIV with Rt=0: no Start, 0 stall, DivZero pulses, HI/LO unchanged.
- MTHI 0xDEAD_BEEF: MUL_Write=1 and SelHL=1 in the same cycle with 0 stall; a following MFHI returns 0xDEADBEEF.
- Flag held high from the previous operation when a new MULT is accepted: the stale flag does not end WAIT, and the op retires only on the new flag.
- Reset_n low during WAIT: all outputs go to 0 asynchronously; after release the block is in IDLE and accepts a new MULT normally.
- Timeout build, flag never rises: after 64 WAIT cycles Error is set and Stall drops; Error stays set until reset.
